// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: takes the bit-reversed FFT output stream and re-emits each frame in natural bin order as one N-cycle burst.
// Optional macro FFT_REORDER_IDX_EN adds odata_idx, the bin number travelling with each output sample.
module fft_bitrev_reorder #(
    parameter int N     = 128,
    parameter int WIDTH = 16,
    localparam int LOG2N = $clog2(N)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             idata_en,
    input  logic [WIDTH-1:0] idata_r,
    input  logic [WIDTH-1:0] idata_i,
    output logic             odata_en,
    output logic [WIDTH-1:0] odata_r,
`ifdef FFT_REORDER_IDX_EN
    output logic [WIDTH-1:0] odata_i,
    output logic [LOG2N-1:0] odata_idx
`else
    output logic [WIDTH-1:0] odata_i
`endif
);
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    logic [2*WIDTH-1:0] r_mem [0:2*N-1];
    logic [LOG2N-1:0]   r_wcnt;
    logic [LOG2N-1:0]   w_wcnt_rev;
    logic               r_wbank;
    logic [LOG2N-1:0]   r_rcnt;
    logic               r_rbank;
    state_t             r_state;
    state_t             w_state_next;
    logic               w_frame_done;
    logic               r_oen;
    logic [WIDTH-1:0]   r_odr;
    logic [WIDTH-1:0]   r_odi;

    generate
        for (genvar gi = 0; gi < LOG2N; gi++) begin : g_bitrev
            assign w_wcnt_rev[gi] = r_wcnt[LOG2N-1-gi];
        end
    endgenerate

    assign w_frame_done = idata_en && (r_wcnt == LAST);

    // Scatter writes at the bit-reversed address so the read side can walk linearly.
    always_ff @(posedge clock) begin
        if (idata_en) begin
            r_mem[{r_wbank, w_wcnt_rev}] <= {idata_r, idata_i};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wcnt  <= '0;
            r_wbank <= 1'b0;
        end else if (idata_en) begin
            r_wcnt <= r_wcnt + 1'b1;
            if (r_wcnt == LAST) begin
                r_wbank <= ~r_wbank;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A frame completing on the final read cycle keeps the FSM in BURST, giving gapless output.
    always_comb begin
        w_state_next = r_state;
        if (r_state == S_IDLE) begin
            if (w_frame_done) begin
                w_state_next = S_BURST;
            end
        end else begin
            if ((r_rcnt == LAST) && !w_frame_done) begin
                w_state_next = S_IDLE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rcnt  <= '0;
            r_rbank <= 1'b0;
            r_oen   <= 1'b0;
            r_odr   <= '0;
            r_odi   <= '0;
`ifdef FFT_REORDER_IDX_EN
            odata_idx <= '0;
`endif
        end else begin
            r_oen <= (r_state == S_BURST);
            if (w_frame_done) begin
                r_rcnt  <= '0;
                r_rbank <= r_wbank;
            end else if (r_state == S_BURST) begin
                r_rcnt <= r_rcnt + 1'b1;
            end
            if (r_state == S_BURST) begin
                {r_odr, r_odi} <= r_mem[{r_rbank, r_rcnt}];
`ifdef FFT_REORDER_IDX_EN
                odata_idx <= r_rcnt;
`endif
            end
        end
    end

    assign odata_en = r_oen;
    assign odata_r  = r_odr;
    assign odata_i  = r_odi;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder (N=128, WIDTH=16): frames driven in bit-reversed order, natural-order output checked from a queue.
module tb_fft_bitrev_reorder;
    localparam int N     = 128;
    localparam int WIDTH = 16;

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] i;
        logic [6:0]       idx;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             idata_en = 1'b0;
    logic [WIDTH-1:0] idata_r = '0;
    logic [WIDTH-1:0] idata_i = '0;
    logic             odata_en;
    logic [WIDTH-1:0] odata_r;
    logic [WIDTH-1:0] odata_i;
`ifdef FFT_REORDER_IDX_EN
    logic [6:0]       odata_idx;
`endif

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_in = 0;
    int   first_out = -1;
    int   run = 0;
    int   last_run = 0;
    int   popped = 0;
    int   base = 0;
    logic prev_en = 1'b0;

    fft_bitrev_reorder #(.N(N), .WIDTH(WIDTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .idata_en (idata_en),
        .idata_r  (idata_r),
        .idata_i  (idata_i),
        .odata_en (odata_en),
        .odata_r  (odata_r),
`ifdef FFT_REORDER_IDX_EN
        .odata_i  (odata_i),
        .odata_idx(odata_idx)
`else
        .odata_i  (odata_i)
`endif
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [6:0] bitrev7(input logic [6:0] k);
        logic [6:0] b;
        for (int j = 0; j < 7; j++) b[j] = k[6-j];
        return b;
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_en = 1'b0;
                run = 0;
            end else if (odata_en) begin
                if (!prev_en) first_out = cyc;
                prev_en = 1'b1;
                run++;
                total++;
                assert (q.size() > 0) else begin
                    bad++;
                    $error("FAIL unexpected_output got r=%0d i=%0d expected no output", odata_r, odata_i);
                end
                if (q.size() > 0) begin
                    e = q.pop_front();
                    popped++;
                    total++;
                    assert ({odata_r, odata_i} === {e.r, e.i}) else begin
                        bad++;
                        $error("FAIL data got r=%0d i=%0d expected r=%0d i=%0d", odata_r, odata_i, e.r, e.i);
                    end
`ifdef FFT_REORDER_IDX_EN
                    total++;
                    assert (odata_idx === e.idx) else begin
                        bad++;
                        $error("FAIL idx got %0d expected %0d", odata_idx, e.idx);
                    end
                    total++;
                    assert (odata_idx === odata_r[6:0]) else begin
                        bad++;
                        $error("FAIL idx_vs_r got %0d expected %0d", odata_idx, odata_r[6:0]);
                    end
`endif
                end
            end else begin
                if (prev_en) last_run = run;
                prev_en = 1'b0;
                run = 0;
            end
        end
    endtask

    // Drives nsamp samples of a frame; expectations are queued only for a complete frame.
    task automatic send_frame(input int off, input int gap, input int nsamp);
        logic [6:0] br;
        for (int k = 0; k < nsamp; k++) begin
            br = bitrev7(7'(k));
            idata_en = 1'b1;
            idata_r  = 16'(int'(br) + off);
            idata_i  = 16'(-(int'(br) + off));
            if (k == N - 1) begin
                for (int b = 0; b < N; b++) begin
                    q.push_back(exp_t'{r: 16'(b + off), i: 16'(-(b + off)), idx: 7'(b)});
                end
            end
            @(posedge clock);
            #1;
            idata_en = 1'b0;
            if (k != nsamp - 1) repeat (gap) begin
                @(posedge clock);
                #1;
            end
        end
        last_in = cyc;
    endtask

    task automatic wait_drain(input int exp_run, input int last_r, input bit chk_lat, input string tag);
        int n = 0;
        while (!(q.size() == 0 && !prev_en) && n < 3000) begin
            @(posedge clock);
            #1;
            n++;
        end
        total++;
        assert (n < 3000) else begin
            bad++;
            $error("FAIL %s_timeout got %0d pending expected 0", tag, q.size());
        end
        total++;
        assert (last_run === exp_run) else begin
            bad++;
            $error("FAIL %s_burst_len got %0d expected %0d", tag, last_run, exp_run);
        end
        if (chk_lat) begin
            total++;
            assert (first_out === last_in + 1) else begin
                bad++;
                $error("FAIL %s_latency got cycle %0d expected %0d", tag, first_out, last_in + 1);
            end
        end
        repeat (3) @(posedge clock);
        #1;
        total++;
        assert (odata_en === 1'b0 && odata_r === 16'(last_r)) else begin
            bad++;
            $error("FAIL %s_hold got en=%0b r=%0d expected en=0 r=%0d", tag, odata_en, odata_r, last_r);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        #3;
        total++;
        assert (odata_en === 1'b0 && odata_r === 16'd0 && odata_i === 16'd0) else begin
            bad++;
            $error("FAIL reset_state got en=%0b r=%0d i=%0d expected 0 0 0", odata_en, odata_r, odata_i);
        end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // 1: single frame, continuous input
        first_out = -1;
        send_frame(0, 0, N);
        wait_drain(N, 127, 1'b1, "t1");

        // 2: same frame, one valid every third cycle
        first_out = -1;
        send_frame(0, 2, N);
        wait_drain(N, 127, 1'b1, "t2");

        // 3: three frames back to back must produce one unbroken 384-cycle burst
        first_out = -1;
        send_frame(256, 0, N);
        send_frame(512, 0, N);
        send_frame(768, 0, N);
        wait_drain(3 * N, 768 + 127, 1'b0, "t3");

        // 4: reset after a partial frame, then a full frame
        send_frame(1024, 0, 50);
        #2;
        reset = 1'b1;
        #1;
        total++;
        assert (odata_en === 1'b0 && odata_r === 16'd0 && odata_i === 16'd0) else begin
            bad++;
            $error("FAIL t4_reset got en=%0b r=%0d i=%0d expected 0 0 0", odata_en, odata_r, odata_i);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        first_out = -1;
        send_frame(1280, 0, N);
        wait_drain(N, 1280 + 127, 1'b1, "t4");

        // 5: reset right after the 60th output sample of a burst
        base = popped;
        send_frame(1536, 0, N);
        for (int n = 0; n < 1000 && popped < base + 60; n++) @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        total++;
        assert (odata_en === 1'b0 && odata_r === 16'd0) else begin
            bad++;
            $error("FAIL t5_async_drop got en=%0b r=%0d expected en=0 r=0", odata_en, odata_r);
        end
        q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (200) @(posedge clock);
        #1;
        total++;
        assert (popped === base + 60) else begin
            bad++;
            $error("FAIL t5_truncated got %0d samples expected %0d", popped - base, 60);
        end
        first_out = -1;
        send_frame(1792, 0, N);
        wait_drain(N, 1792 + 127, 1'b1, "t5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
